// File: rtl/rt_ibex_pcs_restore_seq.sv
// Restore sequencer: captures a popped context bundle and writes it back into the
// register file one word per cycle through the shared write port, stalling the core.
module rt_ibex_pcs_restore_seq #(
  parameter int unsigned NrSavedRegs = 9,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 5,
  parameter logic [NrSavedRegs-1:0][AddrWidth-1:0] RegAddrs =
    {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd7, 5'd6, 5'd5, 5'd1}
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  input  logic                                 core_we_i,
  input  logic [AddrWidth-1:0]                 core_waddr_i,
  input  logic [DataWidth-1:0]                 core_wdata_i,
  output logic                                 rf_we_o,
  output logic [AddrWidth-1:0]                 rf_waddr_o,
  output logic [DataWidth-1:0]                 rf_wdata_o,
  output logic                                 stall_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  localparam int unsigned IdxW = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrSavedRegs - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } state_e;

  state_e                                state_q, state_d;
  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] buf_q, buf_d;
  logic                                  err_q, err_d;

  // NOTE: the capture buffer is reset as well, so an aborted sequence leaves no
  // stale context behind; this is a deliberate cost over leaving it unreset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (restore_en_i) begin
          buf_d   = restore_data_i;
          idx_d   = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Any core write or restore request outside IDLE is a protocol violation.
    if (state_q != StIdle && (core_we_i || restore_en_i)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    stall_o    = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        rf_we_o    = core_we_i;
        rf_waddr_o = core_waddr_i;
        rf_wdata_o = core_wdata_i;
        stall_o    = restore_en_i;
      end
      StWrite: begin
        // Slots mapped to x0 still burn a cycle but never assert the write enable.
        rf_we_o    = (RegAddrs[idx_q] != '0);
        rf_waddr_o = RegAddrs[idx_q];
        rf_wdata_o = buf_q[idx_q];
        stall_o    = 1'b1;
        busy_o     = 1'b1;
      end
      StDone: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_o = err_q;

endmodule
